// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-dump debug sequencer.
package regdump_pkg;

  localparam int unsigned REG_ADR_W         = 5;
  localparam int unsigned XLEN              = 32;
  localparam int unsigned CNT_W             = 4;
  localparam int unsigned SETTLE_CYCLES_DEF = 4;
  localparam int unsigned READ_LAT_DEF      = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WAIT,
    OUT,
    DONE
  } regdump_state_t;

endpackage

// File: rtl/regdump_ctrl.sv
// Debug-port sequencer: freezes the core, walks a register range through
// debug_input and streams (address, data) beats on a valid/ready port.
module regdump_ctrl
  import regdump_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned READ_LAT      = READ_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [REG_ADR_W-1:0] first_reg,
  input  logic [REG_ADR_W-1:0] last_reg,
  output logic                 busy,
  output logic                 done,
  output logic                 core_debug,
  output logic [REG_ADR_W-1:0] core_debug_input,
  input  logic [XLEN-1:0]      core_debug_output,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [REG_ADR_W-1:0] dump_addr,
  output logic [XLEN-1:0]      dump_data
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LD    = CNT_W'(READ_LAT - 1);

  regdump_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [REG_ADR_W-1:0] cur_addr_q, cur_addr_d;
  logic [REG_ADR_W-1:0] end_addr_q, end_addr_d;
  logic [REG_ADR_W-1:0] dump_addr_q, dump_addr_d;
  logic [XLEN-1:0]      dump_data_q, dump_data_d;
  logic                 busy_q, done_q, dbg_q, valid_q;
  logic [REG_ADR_W-1:0] dbg_in_q;
  logic                 hs;

  assign hs = valid_q & dump_ready;

  // Next-state logic; the delay counter is reloaded on every SETTLE/WAIT entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_addr_d  = cur_addr_q;
    end_addr_d  = end_addr_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cur_addr_d = first_reg;
          end_addr_d = last_reg;
          cnt_d      = SETTLE_LD;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          cnt_d   = LAT_LD;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          dump_data_d = core_debug_output;
          dump_addr_d = cur_addr_q;
          state_d     = OUT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      OUT: begin
        // A beat handshaken alongside abort still counts as transferred.
        if (hs) begin
          if (cur_addr_q == end_addr_q) begin
            state_d = DONE;
          end else begin
            cur_addr_d = cur_addr_q + REG_ADR_W'(1);
            cnt_d      = LAT_LD;
            state_d    = WAIT;
          end
        end
        if (abort) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and datapath registers.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_addr_q  <= '0;
      end_addr_q  <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_addr_q  <= cur_addr_d;
      end_addr_q  <= end_addr_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

  // Outputs decoded from the next state and registered, so they line up with state_q.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbg_q    <= 1'b0;
      valid_q  <= 1'b0;
      dbg_in_q <= '0;
    end else begin
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
      dbg_q    <= (state_d == SETTLE) || (state_d == WAIT) || (state_d == OUT);
      valid_q  <= (state_d == OUT);
      dbg_in_q <= cur_addr_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign core_debug       = dbg_q;
  assign core_debug_input = dbg_in_q;
  assign dump_valid       = valid_q;
  assign dump_addr        = dump_addr_q;
  assign dump_data        = dump_data_q;

endmodule

// File: tb/tb_regdump_ctrl.sv
// Directed self-checking bench for regdump_ctrl with a two-cycle core read model.
module tb_regdump_ctrl;

  logic        clk;
  logic        Rst;
  logic        start;
  logic        abort;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic        busy;
  logic        done;
  logic        core_debug;
  logic [4:0]  core_debug_input;
  logic [31:0] core_debug_output;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;

  logic [31:0] regs [32];

  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned beats, first_t, last_t, done_t;
  logic [31:0] last_d;

  regdump_ctrl #(.SETTLE_CYCLES(4), .READ_LAT(2)) dut (
    .clk               (clk),
    .Rst               (Rst),
    .start             (start),
    .abort             (abort),
    .first_reg         (first_reg),
    .last_reg          (last_reg),
    .busy              (busy),
    .done              (done),
    .core_debug        (core_debug),
    .core_debug_input  (core_debug_input),
    .core_debug_output (core_debug_output),
    .dump_valid        (dump_valid),
    .dump_ready        (dump_ready),
    .dump_addr         (dump_addr),
    .dump_data         (dump_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: combinational register-file read followed by an output register.
  always @(posedge clk) core_debug_output <= regs[core_debug_input];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_dbg"}, 32'(core_debug), 32'd0);
    check({tag, "_valid"}, 32'(dump_valid), 32'd0);
  endtask

  // Runs one dump from the current sample point; stall = cycles of ready low per beat.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                          input int unsigned stall, input bit repulse);
    logic [4:0]  exp_a;
    logic [4:0]  hold_a;
    logic [31:0] hold_d;
    int unsigned t, wcnt, dbg_bad;
    bit          fin, pulsed;
    exp_a = f; beats = 0; first_t = 0; last_t = 0; done_t = 0; last_d = '0;
    wcnt = 0; dbg_bad = 0; fin = 0; pulsed = 0; hold_a = '0; hold_d = '0;
    first_reg = f; last_reg = l; start = 1'b1; dump_ready = 1'b1;
    tick();
    t = 1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!fin && t < 600) begin
      if (done) begin
        done_t = t;
        fin = 1;
        check("done_dbg_low", 32'(core_debug), 32'd0);
        check("done_valid_low", 32'(dump_valid), 32'd0);
      end else begin
        if (!core_debug) dbg_bad++;
        if (dump_valid) begin
          if (first_t == 0) first_t = t;
          if (wcnt == 0) begin
            hold_a = dump_addr;
            hold_d = dump_data;
          end
          if (wcnt < stall) begin
            dump_ready = 1'b0;
            wcnt++;
          end else begin
            if (stall > 0) begin
              check("stall_addr_stable", 32'(dump_addr), 32'(hold_a));
              check("stall_data_stable", dump_data, hold_d);
            end
            check("beat_addr", 32'(dump_addr), 32'(exp_a));
            check("beat_data", dump_data, regs[exp_a]);
            beats++;
            last_t = t;
            last_d = dump_data;
            exp_a  = exp_a + 5'd1;
            wcnt   = 0;
            dump_ready = 1'b1;
            if (repulse && !pulsed) begin
              start = 1'b1; first_reg = 5'd20; last_reg = 5'd20; pulsed = 1;
            end
          end
        end
        tick();
        t++;
        start = 1'b0;
      end
    end
    if (!fin) check("done_timeout", 32'd0, 32'd1);
    check("dbg_held_during_dump", 32'(dbg_bad), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check_idle("after_done");
  endtask

  initial begin
    Rst = 1'b0; start = 1'b0; abort = 1'b0; dump_ready = 1'b1;
    first_reg = '0; last_reg = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbg", 32'(core_debug), 32'd0);
    check("rst_dbg_in", 32'(core_debug_input), 32'd0);
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_addr", 32'(dump_addr), 32'd0);
    check("rst_data", dump_data, 32'd0);
    @(negedge clk) Rst = 1'b1;
    tick();
    check_idle("post_rst");

    // Full dump 0..31 with ready high
    run_dump(5'd0, 5'd31, 0, 0);
    check("full_beats", 32'(beats), 32'd32);
    check("full_first_t", 32'(first_t), 32'd7);
    check("full_last_t", 32'(last_t), 32'd100);
    check("full_done_t", 32'(done_t), 32'(last_t + 1));
    check("full_last_data", last_d, 32'h1000_001F);

    // Back-pressure: 10 cycles of ready low per beat
    run_dump(5'd5, 5'd7, 10, 0);
    check("bp_beats", 32'(beats), 32'd3);

    // Wrap range through 31 -> 0, with x0 reading as zero
    regs[0] = 32'h0;
    run_dump(5'd30, 5'd1, 0, 0);
    check("wrap_beats", 32'(beats), 32'd4);

    // Single register
    run_dump(5'd9, 5'd9, 0, 0);
    check("single_beats", 32'(beats), 32'd1);
    check("single_data", last_d, 32'h1000_0009);

    // start re-pulsed with first=20 mid-dump is ignored
    run_dump(5'd10, 5'd12, 0, 1);
    check("repulse_beats", 32'(beats), 32'd3);

    // Abort during the third WAIT of a full dump
    first_reg = 5'd0; last_reg = 5'd31; dump_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("abort_pre_wait", 32'(dump_valid), 32'd0);
    check("abort_pre_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort");
    check("abort_no_done", 32'(done), 32'd0);
    run_dump(5'd3, 5'd4, 0, 0);
    check("after_abort_beats", 32'(beats), 32'd2);

    // Asynchronous reset while a beat is held valid
    first_reg = 5'd2; last_reg = 5'd4; dump_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("rstmid_valid", 32'(dump_valid), 32'd1);
    check("rstmid_data_pre", dump_data, 32'h1000_0002);
    #2 Rst = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_dbg", 32'(core_debug), 32'd0);
    check("rstmid_dbg_in", 32'(core_debug_input), 32'd0);
    check("rstmid_valid0", 32'(dump_valid), 32'd0);
    check("rstmid_addr", 32'(dump_addr), 32'd0);
    check("rstmid_data", dump_data, 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    @(negedge clk) Rst = 1'b1;
    dump_ready = 1'b1;
    tick();
    check_idle("rstmid_release");
    tick();
    check("rstmid_no_done", 32'(done), 32'd0);
    check_idle("rstmid_idle2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regdump_ctrl.md
# regdump_ctrl

Debug-port sequencer for the Mini-RISC-V core. On a single `start` pulse it freezes the pipeline through the core's `debug` input, then walks a range of architectural registers through `debug_input`. It captures each `debug_output` word and streams it out as (address, data) beats on a valid/ready interface, so a UART or JTAG bridge can dump the register file without manually driving the debug port.

## Interface
- `SETTLE_CYCLES`, default 4: cycles `debug` is held before the first read, so the frozen pipeline settles.
- `READ_LAT`, default 2: cycles from a `debug_input` change to a valid `debug_output` (register-file read plus output register). Legal range 1..15.
- `clk` in 1: system clock. All logic is on the rising edge.
- `Rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a dump. Sampled only in IDLE.
- `abort` in 1: terminate any dump. Has priority over `start`.
- `first_reg` in 5: first register index. Latched when `start` is accepted.
- `last_reg` in 5: last register index. Latched when `start` is accepted.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `core_debug` out 1: drives the core `debug` input.
- `core_debug_input` out 5: drives the core `debug_input`.
- `core_debug_output` in 32: taken from the core `debug_output`.
- `dump_valid` out 1: beat available.
- `dump_ready` in 1: sink accepts the beat.
- `dump_addr` out 5: register index of the beat.
- `dump_data` out 32: register contents.

## Operation
- **States:** IDLE, SETTLE, WAIT, OUT, DONE.
- **Reset:** state goes to IDLE. Every output is 0, including the address/latency counters and `dump_data`.
- **IDLE:**
  - With `start=1` and `abort=0`, latch `cur_addr<=first_reg` and `end_addr<=last_reg`, and go to SETTLE.
  - `start` in any other state is ignored.
- **SETTLE:**
  - Counts `SETTLE_CYCLES` cycles, then goes to WAIT.
  - `core_debug=1` and `core_debug_input=cur_addr` in SETTLE, WAIT and OUT.
- **WAIT:**
  - Counts `READ_LAT` cycles with `cur_addr` stable.
  - On the last WAIT cycle, register `dump_data<=core_debug_output` and `dump_addr<=cur_addr`, then go to OUT.
- **OUT:**
  - `dump_valid=1`. `dump_addr` and `dump_data` are held stable until the handshake (`dump_valid & dump_ready`).
  - On handshake with `cur_addr==end_addr`, go to DONE.
  - On handshake otherwise, `cur_addr<=cur_addr+1` (5-bit, wraps 31→0) and go to WAIT.
- **DONE:** `core_debug=0`, `done=1`, `busy=1`, `dump_valid=0`. Always returns to IDLE the next cycle.
- **Range:**
  - `first_reg==last_reg` yields exactly one beat.
  - `first_reg>last_reg` wraps through 31 to 0, giving (32-first+last+1) beats.
  - `first=0, last=31` yields 32 beats.
  - x0 is read like any other register.
- **Abort:**
  - In SETTLE, WAIT or OUT, the next state is IDLE, with `core_debug=0` and `dump_valid=0` from the next cycle. No `done` pulse.
  - A beat that is valid and ready in the same cycle as `abort` is counted as transferred.
- **Outputs:** all are registered (Moore decode from state). No combinational path from any input to any output.

## Timing
- `start` sampled at cycle N:
  - SETTLE runs N+1 .. N+SETTLE_CYCLES.
  - WAIT runs N+SETTLE_CYCLES+1 .. N+SETTLE_CYCLES+READ_LAT.
  - First `dump_valid` is at N+SETTLE_CYCLES+READ_LAT+1 (N+7 with defaults).
- With `dump_ready` tied high, beats arrive every READ_LAT+1 cycles (3 with defaults).
- Last handshake at cycle M: `done` and `core_debug=0` at M+1, IDLE with `busy=0` at M+2. The earliest next `start` is accepted at M+2.
- Back-pressure stretches OUT indefinitely. `core_debug` stays high throughout, so the core remains frozen.
- Asynchronous reset mid-dump: all outputs drop to 0 immediately, and `core_debug` releases the core without a `done` pulse.

## Structure
- Package `regdump_pkg` holds:
  - `regdump_state_t` enum: IDLE, SETTLE, WAIT, OUT, DONE.
  - `REG_ADR_W=5` and `XLEN=32`.
  - The default `SETTLE_CYCLES`/`READ_LAT` localparams.
- Single module, no sub-modules. It contains one 4-bit delay counter shared by SETTLE and WAIT, plus a 5-bit address counter.

## Test plan
- **Full dump:** regs preloaded with x_n = 0x1000_0000+n, `first=0`, `last=31`, `ready=1`, `start` at N.
  - First beat (addr 0, 0x1000_0000) at N+7.
  - Beats every 3 cycles; the 32nd beat is addr 31, 0x1000_001F.
  - `done` one cycle after the last beat; `core_debug` high N+1 through the last beat.
- **Back-pressure:** `first=5`, `last=7`, `ready` low for 10 cycles at each beat.
  - `dump_addr` and `dump_data` stay stable while `ready` is low.
  - Exactly 3 beats (5, 6, 7), then `done`.
- **Wrap range:** `first=30`, `last=1`.
  - Beats in order 30, 31, 0 (data 0), 1, then `done`.
  - `first=last=9` gives a single beat, addr 9.
- **Abort:** `abort` during the 3rd WAIT of a full dump.
  - Next cycle: `core_debug=0`, `busy=0`, no `done`, no further beats.
  - A `start` 1 cycle later is accepted normally.
- **Start while busy:** `start` re-pulsed with `first=20` mid-dump.
  - Ignored: the sequence continues the original range unchanged.
- **Reset mid-OUT:** `Rst` low asynchronously while `dump_valid=1`.
  - All outputs 0 within the same cycle.
  - After release, IDLE; the core runs with `debug=0`.
